// File: rtl/sevseg_scan.sv
// sevseg_scan: time-multiplexed seven-segment driver with a hex decoder,
// frame-synchronous double buffering, leading-zero blanking, PWM brightness
// and a one-tick anti-ghosting guard at the start of every digit slot.
module sevseg_scan #(
  parameter int NUM_DIGITS     = 8,
  parameter int CLK_DIV        = 100000,
  parameter bit ACTIVE_LOW_SEG = 1'b1,
  parameter bit ACTIVE_LOW_AN  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    blank_lz,
  input  logic [3:0]              brightness,
  input  logic                    load,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int TICK_W = $clog2(CLK_DIV);
  localparam int IDX_W  = $clog2(NUM_DIGITS);

  localparam logic [TICK_W-1:0]     TICK_MAX = TICK_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_MAX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [31:0]           ON_MAX   = 32'(CLK_DIV - 1);
  localparam logic [7:0]            SEG_OFF  = ACTIVE_LOW_SEG ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = ACTIVE_LOW_AN ? {NUM_DIGITS{1'b1}} : '0;

  // Everything a load captures; staging and shadow share this layout.
  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    blank_lz;
    logic [3:0]              brightness;
  } cfg_t;

  localparam cfg_t CFG_RESET = '{value: '0, dp: '0, digit_en: '0,
                                 blank_lz: 1'b0, brightness: 4'hF};

  // Active-high a..g pattern for one hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    unique case (h)
      4'h0: hex_to_seg = 7'h3F;
      4'h1: hex_to_seg = 7'h06;
      4'h2: hex_to_seg = 7'h5B;
      4'h3: hex_to_seg = 7'h4F;
      4'h4: hex_to_seg = 7'h66;
      4'h5: hex_to_seg = 7'h6D;
      4'h6: hex_to_seg = 7'h7D;
      4'h7: hex_to_seg = 7'h07;
      4'h8: hex_to_seg = 7'h7F;
      4'h9: hex_to_seg = 7'h67;
      4'hA: hex_to_seg = 7'h77;
      4'hB: hex_to_seg = 7'h7C;
      4'hC: hex_to_seg = 7'h58;
      4'hD: hex_to_seg = 7'h5E;
      4'hE: hex_to_seg = 7'h79;
      default: hex_to_seg = 7'h71;
    endcase
  endfunction

  logic [TICK_W-1:0]     tick_q, tick_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  pending_q, pending_d;
  cfg_t                  stage_q, stage_d;
  cfg_t                  shadow_q, shadow_d;
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_done_q, frame_done_d;

  logic                  boundary;
  cfg_t                  in_cfg;
  logic [NUM_DIGITS-1:0] lz_supp;
  logic                  zero_run;
  logic [31:0]           on_raw;
  logic [31:0]           on_cycles;
  logic [3:0]            nib;
  logic                  dig_en;
  logic [7:0]            pat;
  logic [NUM_DIGITS-1:0] an_hot;

  assign in_cfg = '{value: value, dp: dp, digit_en: digit_en,
                    blank_lz: blank_lz, brightness: brightness};

  // Slot tick and digit index; the frame boundary is the last tick of the last digit.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    tick_d   = tick_q + 1'b1;
    idx_d    = idx_q;
    boundary = (idx_q == IDX_MAX) && (tick_q == TICK_MAX);
    if (tick_q == TICK_MAX) begin
      tick_d = '0;
      idx_d  = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end
  end

  // Double buffer: loads land in staging, staging moves to the shadow only at a frame boundary.
  always_comb begin
    stage_d   = stage_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    if (load) stage_d = in_cfg;
    if (boundary) begin
      if (load)           shadow_d = in_cfg;
      else if (pending_q) shadow_d = stage_q;
      pending_d = 1'b0;
    end else if (load) begin
      pending_d = 1'b1;
    end
  end

  // Pattern and anode gating for the current slot, computed from the shadow only.
  always_comb begin
    lz_supp  = '0;
    zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run   = zero_run && (shadow_q.value[4*k +: 4] == 4'h0);
      lz_supp[k] = zero_run && (k != 0) && shadow_q.blank_lz;
    end

    on_raw    = ((32'(shadow_q.brightness) + 32'd1) * 32'(CLK_DIV)) >> 4;
    on_cycles = (on_raw > ON_MAX) ? ON_MAX : on_raw;

    nib    = shadow_q.value[4*int'(idx_q) +: 4];
    dig_en = shadow_q.digit_en[idx_q];
    pat    = '0;
    if (dig_en) begin
      pat[7]   = shadow_q.dp[idx_q];
      pat[6:0] = lz_supp[idx_q] ? 7'h00 : hex_to_seg(nib);
    end

    // Tick 0 is the guard cycle: the previous digit's anode is released before the next one drives.
    an_hot = '0;
    if (dig_en && (tick_q != '0) && (32'(tick_q) <= on_cycles)) an_hot[idx_q] = 1'b1;

    seg_d        = ACTIVE_LOW_SEG ? ~pat : pat;
    an_d         = ACTIVE_LOW_AN ? ~an_hot : an_hot;
    frame_done_d = boundary;
  end

  // Counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (!rst_n) begin
      tick_q <= '0;
      idx_q  <= '0;
    end else begin
      tick_q <= tick_d;
      idx_q  <= idx_d;
    end
  end

  // Staging and shadow registers; the shadow resets to a dark, full-brightness configuration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q   <= CFG_RESET;
      shadow_q  <= CFG_RESET;
      pending_q <= 1'b0;
    end else begin
      stage_q   <= stage_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
    end
  end

  // Registered pin drivers, one cycle behind the counter/shadow state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q        <= SEG_OFF;
      an_q         <= AN_OFF;
      frame_done_q <= 1'b0;
    end else begin
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sevseg_scan.sv
// Self-checking bench for sevseg_scan (4 digits, 16 cycles per slot, active-low pins).
// The reference model derives each cycle's pins from the absolute cycle position and
// the list of loads: frame f shows the latest load made at or before the last cycle of frame f-1.
module tb_sevseg_scan;

  localparam int ND    = 4;
  localparam int CD    = 16;
  localparam int FRAME = ND * CD;

  logic          clk;
  logic          rst_n;
  logic [15:0]   value;
  logic [3:0]    dp;
  logic [3:0]    digit_en;
  logic          blank_lz;
  logic [3:0]    brightness;
  logic          load;
  logic [7:0]    seg;
  logic [3:0]    an;
  logic          frame_done;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          p;
    logic [15:0] v;
    logic [3:0]  dp;
    logic [3:0]  en;
    logic        blz;
    logic [3:0]  br;
  } ld_t;

  typedef struct packed {
    logic [7:0] seg;
    logic [3:0] an;
    logic       fd;
  } exp_t;

  ld_t lq[$];
  int  pos;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h67, 7'h77, 7'h7C, 7'h58, 7'h5E, 7'h79, 7'h71};

  sevseg_scan #(
    .NUM_DIGITS(ND), .CLK_DIV(CD), .ACTIVE_LOW_SEG(1'b1), .ACTIVE_LOW_AN(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .dp(dp), .digit_en(digit_en),
    .blank_lz(blank_lz), .brightness(brightness), .load(load),
    .seg(seg), .an(an), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle position since reset release and the history of loads seen at rising edges.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos <= 0;
      lq.delete();
    end else begin
      if (load) lq.push_back('{p: pos, v: value, dp: dp, en: digit_en, blz: blank_lz, br: brightness});
      pos <= pos + 1;
    end
  end

  // Expected pins after the edge that consumed cycle position p.
  function automatic exp_t expect_at(input int p);
    exp_t        e;
    int          frame, idx, tick, lim, on;
    logic [15:0] v;
    logic [3:0]  dpv, env, br, nib;
    logic        blz, supp;
    logic [7:0]  pat;
    frame = p / FRAME;
    idx   = (p / CD) % ND;
    tick  = p % CD;
    lim   = FRAME * frame - 1;
    v = 16'h0; dpv = 4'h0; env = 4'h0; blz = 1'b0; br = 4'hF;
    foreach (lq[i]) begin
      if (lq[i].p <= lim) begin
        v = lq[i].v; dpv = lq[i].dp; env = lq[i].en; blz = lq[i].blz; br = lq[i].br;
      end
    end
    nib  = v[4*idx +: 4];
    supp = blz && (idx != 0) && ((v >> (4 * idx)) == 16'h0);
    on   = ((int'(br) + 1) * CD) >> 4;
    if (on > CD - 1) on = CD - 1;
    pat  = {dpv[idx], supp ? 7'h00 : seg_tab[nib]};
    e.seg = env[idx] ? ~pat : 8'hFF;
    e.an  = (env[idx] && tick >= 1 && tick <= on) ? ~(4'b0001 << idx) : 4'hF;
    e.fd  = (p % FRAME) == FRAME - 1;
    return e;
  endfunction

  // Caller sits on a falling edge; the load is seen by the next rising edge.
  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] en,
                         input logic blz, input logic [3:0] br);
    value = v; dp = d; digit_en = en; blank_lz = blz; brightness = br; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Advance to the falling edge where pos % FRAME == m (bounded).
  task automatic wait_phase(input int m);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((pos % FRAME) != m && n < 3 * FRAME);
    checks++;
    if ((pos % FRAME) != m) begin
      failures++;
      $display("FAIL wait_phase pos=%0d wanted_mod=%0d", pos, m);
    end
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0; load = 1'b0; value = '0; dp = '0; digit_en = '0; blank_lz = 1'b0; brightness = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (seg !== 8'hFF) begin failures++; $display("FAIL reset_seg got=%h exp=ff", seg); end
    checks++;
    if (an !== 4'hF) begin failures++; $display("FAIL reset_an got=%b exp=1111", an); end
    checks++;
    if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_fd got=%b exp=0", frame_done); end
    rst_n = 1'b1;
    repeat (2 * FRAME) begin
      @(negedge clk);
      e = expect_at(pos - 1);
      checks++;
      if ({seg, an, frame_done} !== {e.seg, e.an, e.fd}) begin
        failures++;
        $display("FAIL reset_dark p=%0d seg=%h/%h an=%b/%b fd=%b/%b", pos - 1, seg, e.seg, an, e.an, frame_done, e.fd);
      end
    end
  endtask

  task automatic test_basic_scan();
    exp_t       e;
    logic [7:0] lit [4];
    lit[0] = ~8'h71; lit[1] = ~8'h77; lit[2] = ~8'h5B; lit[3] = ~8'h06;
    do_load(16'h12AF, 4'h0, 4'hF, 1'b0, 4'hF);
    repeat (3 * FRAME) begin
      @(negedge clk);
      e = expect_at(pos - 1);
      checks++;
      if ({seg, an, frame_done} !== {e.seg, e.an, e.fd}) begin
        failures++;
        $display("FAIL basic_scan p=%0d seg=%h/%h an=%b/%b fd=%b/%b", pos - 1, seg, e.seg, an, e.an, frame_done, e.fd);
      end
    end
    wait_phase(6);
    for (int k = 0; k < ND; k++) begin
      checks++;
      if (seg !== lit[k] || an !== ~(4'b0001 << k)) begin
        failures++;
        $display("FAIL basic_slot%0d seg=%h/%h an=%b/%b", k, seg, lit[k], an, ~(4'b0001 << k));
      end
      repeat (CD) @(negedge clk);
    end
  endtask

  task automatic test_leading_zero();
    exp_t       e;
    logic [7:0] lit [4];
    lit[0] = 8'hC0; lit[1] = 8'hB0; lit[2] = 8'hFF; lit[3] = 8'h7F;
    do_load(16'h0030, 4'b1000, 4'hF, 1'b1, 4'hF);
    repeat (2 * FRAME) begin
      @(negedge clk);
      e = expect_at(pos - 1);
      checks++;
      if ({seg, an, frame_done} !== {e.seg, e.an, e.fd}) begin
        failures++;
        $display("FAIL leading_zero p=%0d seg=%h/%h an=%b/%b fd=%b/%b", pos - 1, seg, e.seg, an, e.an, frame_done, e.fd);
      end
    end
    wait_phase(3);
    for (int k = 0; k < ND; k++) begin
      checks++;
      if (seg !== lit[k]) begin
        failures++;
        $display("FAIL lz_slot%0d seg=%h/%h", k, seg, lit[k]);
      end
      repeat (CD) @(negedge clk);
    end
  endtask

  task automatic test_tear_free();
    exp_t e;
    wait_phase(5);
    do_load(16'h1111, 4'h0, 4'hF, 1'b0, 4'hF);
    wait_phase(40);
    do_load(16'h2222, 4'h0, 4'hF, 1'b0, 4'hF);
    repeat (2 * FRAME + 30) begin
      @(negedge clk);
      e = expect_at(pos - 1);
      checks++;
      if ({seg, an, frame_done} !== {e.seg, e.an, e.fd}) begin
        failures++;
        $display("FAIL tear_free p=%0d seg=%h/%h an=%b/%b fd=%b/%b", pos - 1, seg, e.seg, an, e.an, frame_done, e.fd);
      end
      checks++;
      if (seg === ~8'h06) begin
        failures++;
        $display("FAIL tear_stale p=%0d seg=%h (digit 1 pattern shown)", pos - 1, seg);
      end
    end
  endtask

  task automatic test_boundary_load();
    exp_t        e;
    logic [15:0] v;
    v = 16'($urandom);
    wait_phase(FRAME - 1);
    do_load(v, 4'($urandom), 4'hF, 1'b0, 4'hF);
    // First post-load sample is the boundary output; the next cycles are slot 0 of the new frame.
    repeat (FRAME + 8) begin
      @(negedge clk);
      e = expect_at(pos - 1);
      checks++;
      if ({seg, an, frame_done} !== {e.seg, e.an, e.fd}) begin
        failures++;
        $display("FAIL boundary_load p=%0d seg=%h/%h an=%b/%b fd=%b/%b", pos - 1, seg, e.seg, an, e.an, frame_done, e.fd);
      end
    end
  endtask

  task automatic test_brightness();
    exp_t       e;
    int         lit_on [2];
    logic [3:0] lvl [2];
    int         cnt;
    lvl[0] = 4'd3; lit_on[0] = 4;
    lvl[1] = 4'd0; lit_on[1] = 1;
    for (int j = 0; j < 2; j++) begin
      do_load(16'($urandom), 4'h0, 4'hF, 1'b0, lvl[j]);
      wait_phase(0);
      cnt = 0;
      repeat (CD) begin
        @(negedge clk);
        e = expect_at(pos - 1);
        checks++;
        if ({seg, an, frame_done} !== {e.seg, e.an, e.fd}) begin
          failures++;
          $display("FAIL brightness p=%0d seg=%h/%h an=%b/%b fd=%b/%b", pos - 1, seg, e.seg, an, e.an, frame_done, e.fd);
        end
        if (an !== 4'hF) cnt++;
      end
      checks++;
      if (cnt != lit_on[j]) begin
        failures++;
        $display("FAIL brightness_on level=%0d got=%0d exp=%0d", lvl[j], cnt, lit_on[j]);
      end
    end
  endtask

  task automatic test_random();
    exp_t        e;
    logic [15:0] v;
    for (int it = 0; it < 8; it++) begin
      repeat ($urandom_range(1, 100)) begin
        @(negedge clk);
        e = expect_at(pos - 1);
        checks++;
        if ({seg, an, frame_done} !== {e.seg, e.an, e.fd}) begin
          failures++;
          $display("FAIL random p=%0d seg=%h/%h an=%b/%b fd=%b/%b", pos - 1, seg, e.seg, an, e.an, frame_done, e.fd);
        end
      end
      v = 16'($urandom);
      if ($urandom_range(0, 1) == 1) v = v >> (4 * $urandom_range(1, 3));
      do_load(v, 4'($urandom), 4'($urandom), 1'($urandom), 4'($urandom));
    end
    repeat (2 * FRAME) begin
      @(negedge clk);
      e = expect_at(pos - 1);
      checks++;
      if ({seg, an, frame_done} !== {e.seg, e.an, e.fd}) begin
        failures++;
        $display("FAIL random_tail p=%0d seg=%h/%h an=%b/%b fd=%b/%b", pos - 1, seg, e.seg, an, e.an, frame_done, e.fd);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    do_load(16'h8888, 4'hF, 4'hF, 1'b0, 4'hF);
    wait_phase(2 * CD + 3);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (seg !== 8'hFF || an !== 4'hF || frame_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid seg=%h/ff an=%b/1111 fd=%b/0", seg, an, frame_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * FRAME) begin
      @(negedge clk);
      e = expect_at(pos - 1);
      checks++;
      if ({seg, an, frame_done} !== {e.seg, e.an, e.fd}) begin
        failures++;
        $display("FAIL reset_mid_dark p=%0d seg=%h/%h an=%b/%b fd=%b/%b", pos - 1, seg, e.seg, an, e.an, frame_done, e.fd);
      end
    end
    do_load(16'hBEEF, 4'b0101, 4'hF, 1'b0, 4'd7);
    repeat (2 * FRAME) begin
      @(negedge clk);
      e = expect_at(pos - 1);
      checks++;
      if ({seg, an, frame_done} !== {e.seg, e.an, e.fd}) begin
        failures++;
        $display("FAIL reset_mid_reload p=%0d seg=%h/%h an=%b/%b fd=%b/%b", pos - 1, seg, e.seg, an, e.an, frame_done, e.fd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_leading_zero();
    test_tear_free();
    test_boundary_load();
    test_brightness();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sevseg_scan.md
# sevseg_scan

Time-multiplexed driver for a parametrised bank of seven-segment digits with a built-in hex-to-segment decoder. The block takes a packed hex value, per-digit decimal points and digit enables, and scans one digit at a time onto shared segment lines and per-digit anode lines. It adds frame-synchronous double buffering, leading-zero suppression, a PWM brightness control and an anti-ghosting guard cycle. It sits between the core's status/debug registers and the board's display pins.

## Interface
- NUM_DIGITS, 8, number of digits scanned (>=2)
- CLK_DIV, 100000, clock cycles per digit slot (>=16)
- ACTIVE_LOW_SEG, 1, 1 = segment outputs driven low to light
- ACTIVE_LOW_AN, 1, 1 = anode outputs driven low to select
- clk  input  1  system clock; one clock domain, all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- value  input  4*NUM_DIGITS  hex nibbles; nibble i drives digit i; digit NUM_DIGITS-1 is most significant
- dp  input  NUM_DIGITS  decimal point per digit, 1 = lit
- digit_en  input  NUM_DIGITS  1 = digit displayed, 0 = digit dark
- blank_lz  input  1  1 = suppress leading zeros
- brightness  input  4  duty level 0..15
- load  input  1  one-cycle strobe capturing all of the above inputs
- seg  output  8  segments, bit0 = a … bit6 = g, bit7 = dp
- an  output  NUM_DIGITS  digit selects, one-hot when active
- frame_done  output  1  one-cycle pulse at each frame end

## Operation
- Decode (active-high pattern, 7 bits g..a): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:67 A:77 B:7C C:58 D:5E E:79 F:71. Bit7 = dp bit. seg = ~pattern when ACTIVE_LOW_SEG, else pattern. The same inversion rule applies to an with ACTIVE_LOW_AN.
- Counters: tick 0..CLK_DIV-1 and digit_idx 0..NUM_DIGITS-1. tick increments every cycle. On tick wrap, digit_idx increments and wraps to 0 after NUM_DIGITS-1.
- Frame boundary: the cycle with digit_idx == NUM_DIGITS-1 and tick == CLK_DIV-1.
- Buffering:
  - load copies value/dp/digit_en/blank_lz/brightness into staging and sets pending.
  - At a frame boundary with pending set, staging is copied to the display shadow and pending clears.
  - A load in the boundary cycle itself writes the inputs straight into the shadow; pending stays clear.
  - A load while pending is set overwrites staging, so the last load wins.
- Leading-zero suppression (shadow blank_lz = 1): digit k is suppressed if its nibble and all nibbles above k are 0. Digit 0 is never suppressed. Suppression blanks a-g only; dp still follows the dp bit.
- Digit dark when shadow digit_en[k] = 0: segments inactive and anode inactive for the whole slot.
- Brightness: on_cycles = ((brightness+1)*CLK_DIV)>>4, clamped to CLK_DIV-1. The anode of the current digit is active only for tick in [1, on_cycles]. tick 0 is always a guard cycle with all anodes inactive.
- Segment lines carry the current digit's pattern for the whole slot; only an is gated.

## Timing
- seg, an and frame_done are registered. They reflect the counter/shadow state of the previous cycle, so latency is 1 cycle.
- frame_done is high for exactly the cycle after the frame boundary. The shadow update becomes visible on seg/an starting at slot 0 of the new frame.
- Reset values:
  - tick = 0, digit_idx = 0, pending = 0.
  - Staging and shadow all 0, except brightness = 15.
  - seg = all inactive (8'hFF when ACTIVE_LOW_SEG).
  - an = all inactive.
  - frame_done = 0.
- The display stays dark until the first load has reached the shadow, because digit_en resets to 0.
- Reset asserted mid-frame forces all of the above immediately (asynchronous). Scanning restarts at digit 0, tick 0 on the first edge after release.
- Frame period = NUM_DIGITS*CLK_DIV cycles exactly. No input is sampled except on load.

## Test plan
- Basic scan: NUM_DIGITS = 4, CLK_DIV = 16, load value = 16'h12AF, digit_en = 4'hF, brightness = 15 -> in successive slots an = 1110, 1101, 1011, 0111 (active-low), seg = ~8'h71, ~8'h77, ~8'h5B, ~8'h06. Anode is off at tick 0 and on for ticks 1..15; frame_done pulses every 64 cycles.
- Leading zeros: value = 16'h0030, blank_lz = 1, dp = 4'b1000 -> digit 3 shows dp only (seg = 8'h7F), digit 2 is blank (8'hFF), digits 1 and 0 show 3 and 0.
- Tear-free load: load 16'h1111 at cycle 5 of a frame, then 16'h2222 at cycle 40 -> the current frame keeps the old value, the next frame shows only 2222, and 1111 never appears.
- Boundary load: load asserted exactly in the frame-boundary cycle -> the new value is displayed from slot 0 of the very next frame.
- Brightness: brightness = 3, CLK_DIV = 16 -> on_cycles = 4, so the anode is active for ticks 1..4 of each slot and inactive for ticks 0 and 5..15. brightness = 0 -> active on tick 1 only.
- Reset mid-frame: drop rst_n during slot 2 -> seg = 8'hFF, an = all 1, frame_done = 0 immediately. After release, the display is dark until a new load has taken effect.
